// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file through its second read
// port and streams each word out as an (index, data) beat.
module regfile_dump #(
  parameter int NREGS     = 32,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rn,
  input  logic [DW-1:0] q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST = SKIP_ZERO ? AW'(1) : '0;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] oidx_q, oidx_d;
  logic [DW-1:0] odata_q, odata_d;

  // State and beat registers; clr wipes any in-flight beat at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      oidx_q  <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      oidx_q  <= oidx_d;
      odata_q <= odata_d;
    end
  end

  // Next state: abort overrides everything, including a start.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    oidx_d  = oidx_q;
    odata_d = odata_q;
    if (abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_READ;
            idx_d   = FIRST;
          end
        end
        S_READ: begin
          odata_d = q;
          oidx_d  = idx_q;
          valid_d = 1'b1;
          state_d = S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            valid_d = 1'b0;
            if (idx_q == LAST) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = S_READ;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs: the read port is only addressed during READ.
  always_comb begin
    rn        = (state_q == S_READ) ? idx_q : '0;
    busy      = (state_q == S_READ) || (state_q == S_SEND);
    done      = (state_q == S_DONE);
    out_valid = valid_q;
    out_idx   = oidx_q;
    out_data  = odata_q;
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard bench for the register dump engine,
// default build plus a 4-entry build that dumps r0.
module tb_regfile_dump;

  logic        clk;
  logic        clr;
  logic        start, abort, out_ready;
  logic [4:0]  rn;
  logic [31:0] q;
  logic        out_valid, busy, done;
  logic [4:0]  out_idx;
  logic [31:0] out_data;

  logic        start0, ready0;
  logic [1:0]  rn0;
  logic [31:0] q0;
  logic        valid0, busy0, done0;
  logic [1:0]  idx0;
  logic [31:0] data0;

  logic [31:0] rf  [32];
  logic [31:0] rf0 [4];

  logic [36:0] sb  [$];
  logic [33:0] sb0 [$];

  int n_chk = 0;
  int n_fail = 0;

  int          ovr_idx = -1;
  logic [31:0] ovr_val = '0;

  assign q  = rf[rn];
  assign q0 = rf0[rn0];

  regfile_dump dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .rn(rn), .q(q), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .busy(busy), .done(done)
  );

  regfile_dump #(.NREGS(4), .AW(2), .DW(32), .SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .clr(clr), .start(start0), .abort(1'b0),
    .rn(rn0), .q(q0), .out_valid(valid0), .out_ready(ready0),
    .out_idx(idx0), .out_data(data0), .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    if (i == ovr_idx) return ovr_val;
    return 32'h1000_0000 + i;
  endfunction

  task automatic push_dump(input int first, input int last);
    for (int i = first; i <= last; i++)
      sb.push_back({5'(i), exp_word(i)});
  endtask

  // Scoreboard pop on transfers, plus hold check under backpressure.
  logic        p_valid, p_ready, p_abort;
  logic [4:0]  p_idx;
  logic [31:0] p_data;
  initial begin
    p_valid = 1'b0; p_ready = 1'b0; p_abort = 1'b0;
    p_idx = '0; p_data = '0;
  end

  always @(negedge clk) begin
    if (!clr) begin
      if (p_valid && !p_ready && !p_abort)
        chk("hold", {out_valid, out_idx, out_data},
            {1'b1, p_idx, p_data});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("extra_beat", {out_idx, out_data}, 64'hx);
        else chk("beat", {out_idx, out_data}, sb.pop_front());
      end
      p_valid <= out_valid;
      p_ready <= out_ready;
      p_abort <= abort;
      p_idx   <= out_idx;
      p_data  <= out_data;
    end else begin
      p_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!clr && valid0 && ready0) begin
      if (sb0.size() == 0) chk("extra_beat0", {idx0, data0}, 64'hx);
      else chk("beat0", {idx0, data0}, sb0.pop_front());
    end
  end

  // Drives one dump; returns early on an abort/clr trigger.
  task automatic run(input int pct, input int ab_at, input int st_at,
                     input int clr_at, input int wr_at);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = ($urandom_range(0, 99) < pct);
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
      out_ready = ($urandom_range(0, 99) < pct);
      if (out_valid && out_idx == wr_at) rf[20] = 32'hDEAD_BEEF;
      if (out_valid && out_idx == st_at) start = 1'b1;
      if (out_valid && out_idx == ab_at) begin
        abort = 1'b1;
        out_ready = 1'b0;
        ok = 1'b1;
        break;
      end
      if (out_valid && out_idx == clr_at) begin
        #1 clr = 1'b1;
        #1 chk("clr_async", {out_valid, busy, done, rn, out_idx, out_data},
               '0);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout", 1, 0);
  endtask

  task automatic after_done();
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_after", {busy, done, out_valid}, '0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    clr = 1'b1;
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start0 = 1'b0; ready0 = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : 32'h1000_0000 + i;
    rf0[0] = '0;
    for (int i = 1; i < 4; i++) rf0[i] = 32'hA0 + i;
    #2;
    chk("reset", {out_valid, busy, done, rn, out_idx, out_data}, '0);
    chk("reset0", {valid0, busy0, done0, rn0, idx0, data0}, '0);
    @(posedge clk); #1;
    clr = 1'b0;

    // Tied-ready cycle-exact dump on both builds.
    @(posedge clk); #1;
    start = 1'b1; start0 = 1'b1;
    out_ready = 1'b1; ready0 = 1'b1;
    push_dump(1, 31);
    for (int i = 0; i < 4; i++) sb0.push_back({2'(i), rf0[i]});
    @(posedge clk); #1;
    start = 1'b0; start0 = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      chk($sformatf("cyc%0d", c), {out_valid, done, busy},
          {(c % 2 == 0) && (c <= 62), c == 63, c <= 62});
      if (c <= 10)
        chk($sformatf("cyc0_%0d", c), {valid0, done0},
            {(c % 2 == 0) && (c <= 8), c == 9});
    end
    chk("sb_empty", sb.size(), 0);
    chk("sb0_empty", sb0.size(), 0);
    out_ready = 1'b0; ready0 = 1'b0;

    // Random backpressure, ~30% ready.
    push_dump(1, 31);
    run(30, -1, -1, -1, -1);
    after_done();

    // Abort in SEND of idx 7 while stalled.
    push_dump(1, 6);
    run(100, 7, -1, -1, -1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {out_valid, busy, done, rn}, '0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_nodone", {done, busy}, '0);
    end
    chk("sb_empty", sb.size(), 0);

    // Restart from idx 1; a start during SEND of idx 3 is ignored.
    push_dump(1, 31);
    run(100, -1, 3, -1, -1);
    after_done();

    // Abort and start together in IDLE: abort wins.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_wins", {busy, out_valid}, '0);

    // Asynchronous clear at idx 12.
    push_dump(1, 11);
    run(100, -1, -1, 12, -1);
    chk("sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    out_ready = 1'b0;

    // Write r20 mid-dump; the beat must carry the new value.
    ovr_idx = 20;
    ovr_val = 32'hDEAD_BEEF;
    push_dump(1, 31);
    run(100, -1, -1, -1, 5);
    after_done();
    rf[20] = 32'h1000_0014;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
